// File: rtl/ps2_key_pkg.sv
// Shared types, scan-code constants and the default key map for the PS/2 key event unit.
package ps2_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_SKIP    = 3'd4
  } state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;

  localparam int unsigned KEY_IDX_W = 7;
  localparam int unsigned EV_W      = 8;
  localparam int unsigned SKIP_W    = 3;
  // Pause is E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1
  localparam logic [SKIP_W-1:0] PAUSE_TAIL = 3'd7;

  localparam int unsigned MAP_KEYS  = 16;
  localparam int unsigned MAP_IDX_W = $clog2(MAP_KEYS);

  typedef struct packed {
    logic                 brk;
    logic [KEY_IDX_W-1:0] key;
  } key_event_t;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_hit_t;

  // {ext, code}: arrows, 1-5, T, R, P, W, A, S, D
  localparam logic [8:0] KEY_CODE [MAP_KEYS] = '{
    9'h175, 9'h172, 9'h16B, 9'h174,
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h02C, 9'h02D, 9'h04D,
    9'h01D, 9'h01C, 9'h01B, 9'h023
  };

  localparam int unsigned KEY_CHANNEL [MAP_KEYS] = '{
    0, 0, 0, 0,
    0, 0, 0, 0, 0,
    0, 0, 0,
    1, 1, 1, 1
  };

  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code,
                                          input int unsigned num_keys);
    key_hit_t res;
    res = '0;
    for (int unsigned i = 0; i < MAP_KEYS; i++) begin
      if (!res.hit && (i < num_keys) && (KEY_CODE[MAP_IDX_W'(i)] == {ext, code})) begin
        res.hit = 1'b1;
        res.idx = KEY_IDX_W'(i);
      end
    end
    return res;
  endfunction

  function automatic int unsigned key_channel(input int unsigned k);
    return (k < MAP_KEYS) ? KEY_CHANNEL[MAP_IDX_W'(k)] : 0;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Push while full is accepted only when a pop frees the head in the same cycle.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;
  logic          w_full;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_full  = w_full;
  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_event_unit.sv
// PS/2 set-2 keyboard front end: prefix decoder, held-key map, per-channel indicators
// and a make/break event FIFO drained by the processor.
module ps2_key_event_unit
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 16,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [7:0]              ps2_key_data,
  input  logic                    ps2_key_pressed,
  output logic [NUM_KEYS-1:0]     key_held,
  output logic [NUM_CHANNELS-1:0] chan_active,
  output logic [NUM_CHANNELS-1:0] chan_strobe,
  output logic                    ev_valid,
  output logic [7:0]              ev_data,
  input  logic                    ev_pop,
  output logic [CNT_W-1:0]        ev_count,
  output logic                    ev_overflow,
  input  logic                    ovf_clear
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [SKIP_W-1:0]       r_skip;
  logic [SKIP_W-1:0]       w_skip_nxt;
  logic                    w_is_prefix;
  logic                    w_term;
  logic                    w_ext;
  logic                    w_brk;
  key_hit_t                w_lk;

  logic [NUM_KEYS-1:0]     r_key_held;
  logic [NUM_KEYS-1:0]     w_held_nxt;
  logic [NUM_CHANNELS-1:0] r_chan_active;
  logic [NUM_CHANNELS-1:0] w_chan_nxt;
  logic [NUM_CHANNELS-1:0] r_chan_strobe;
  logic [NUM_CHANNELS-1:0] w_strobe_nxt;
  logic                    r_ovf;
  logic                    w_push;
  key_event_t              w_ev;
  logic                    w_full;
  logic                    w_drop;

  assign w_is_prefix = (ps2_key_data == SC_E0) || (ps2_key_data == SC_F0) ||
                       (ps2_key_data == SC_E1);

  // Decoder state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // Decoder next state; only strobed bytes advance it
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    if (ps2_key_pressed) begin
      case (r_state)
        ST_IDLE: begin
          if (ps2_key_data == SC_E0)      w_state_nxt = ST_EXT;
          else if (ps2_key_data == SC_F0) w_state_nxt = ST_BRK;
          else if (ps2_key_data == SC_E1) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = PAUSE_TAIL;
          end
        end
        ST_EXT:  w_state_nxt = (ps2_key_data == SC_F0) ? ST_EXT_BRK : ST_IDLE;
        ST_SKIP: begin
          w_skip_nxt = r_skip - SKIP_W'(1);
          if (r_skip == SKIP_W'(1)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Decoder outputs: terminal byte flag with its extended/break qualifiers
  always_comb begin
    w_term = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (ps2_key_pressed && !w_is_prefix) begin
      case (r_state)
        ST_IDLE:    w_term = 1'b1;
        ST_EXT:     begin w_term = 1'b1; w_ext = 1'b1; end
        ST_BRK:     begin w_term = 1'b1; w_brk = 1'b1; end
        ST_EXT_BRK: begin w_term = 1'b1; w_ext = 1'b1; w_brk = 1'b1; end
        default:    w_term = 1'b0;
      endcase
    end
  end

  assign w_lk = key_lookup(w_ext, ps2_key_data, NUM_KEYS);

  // Accept rules: first make and real release produce events; repeats and stray breaks do not
  always_comb begin
    w_held_nxt   = r_key_held;
    w_strobe_nxt = '0;
    w_push       = 1'b0;
    w_ev         = '0;
    if (w_term && w_lk.hit) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (w_lk.idx == KEY_IDX_W'(k)) begin
          if (!w_brk && !r_key_held[k]) begin
            w_held_nxt[k] = 1'b1;
            w_push        = 1'b1;
            w_ev          = '{brk: 1'b0, key: w_lk.idx};
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
              if (key_channel(k) == c) w_strobe_nxt[c] = 1'b1;
            end
          end else if (w_brk && r_key_held[k]) begin
            w_held_nxt[k] = 1'b0;
            w_push        = 1'b1;
            w_ev          = '{brk: 1'b1, key: w_lk.idx};
          end
        end
      end
    end
  end

  always_comb begin
    w_chan_nxt = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if ((key_channel(k) == c) && w_held_nxt[k]) w_chan_nxt[c] = 1'b1;
      end
    end
  end

  assign w_drop = w_push && w_full && !ev_pop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_held    <= '0;
      r_chan_active <= '0;
      r_chan_strobe <= '0;
      r_ovf         <= 1'b0;
    end else begin
      r_key_held    <= w_held_nxt;
      r_chan_active <= w_chan_nxt;
      r_chan_strobe <= w_strobe_nxt;
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clear) r_ovf <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EV_W)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_push  (w_push),
    .i_data  (w_ev),
    .i_pop   (ev_pop),
    .o_data  (ev_data),
    .o_valid (ev_valid),
    .o_full  (w_full),
    .o_count (ev_count)
  );

  assign key_held    = r_key_held;
  assign chan_active = r_chan_active;
  assign chan_strobe = r_chan_strobe;
  assign ev_overflow = r_ovf;

endmodule

// File: tb/tb_ps2_key_event_unit.sv
// Randomised and directed bench for ps2_key_event_unit against a key-action level model.
module tb_ps2_key_event_unit;

  localparam int NK = 16;
  localparam int NC = 2;
  localparam int FD = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    ps2_key_data = 8'h00;
  logic          ps2_key_pressed = 1'b0;
  logic          ev_pop = 1'b0;
  logic          ovf_clear = 1'b0;
  logic [NK-1:0] key_held;
  logic [NC-1:0] chan_active;
  logic [NC-1:0] chan_strobe;
  logic          ev_valid;
  logic [7:0]    ev_data;
  logic [CW-1:0] ev_count;
  logic          ev_overflow;

  ps2_key_event_unit #(.NUM_KEYS(NK), .NUM_CHANNELS(NC), .FIFO_DEPTH(FD)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .key_held        (key_held),
    .chan_active     (chan_active),
    .chan_strobe     (chan_strobe),
    .ev_valid        (ev_valid),
    .ev_data         (ev_data),
    .ev_pop          (ev_pop),
    .ev_count        (ev_count),
    .ev_overflow     (ev_overflow),
    .ovf_clear       (ovf_clear)
  );

  always #50 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Bench-side key map: scan code and extended flag per key index
  logic [7:0] kcode [16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h2C, 8'h2D, 8'h4D, 8'h1D, 8'h1C, 8'h1B, 8'h23};
  bit         kext  [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int KEY_W = 12;
  localparam int KEY_UP = 0;

  logic [NK-1:0] m_held;
  logic [7:0]    m_q[$];
  logic          m_ovf;
  logic [NC-1:0] m_strobe;

  function automatic logic [NC-1:0] m_chan();
    logic [NC-1:0] c = '0;
    for (int i = 0; i < NK; i++) if (m_held[i]) c[(i >= 12) ? 1 : 0] = 1'b1;
    return c;
  endfunction

  function automatic logic [NK+NC+CW+1:0] exp_vec();
    return {m_held, m_chan(), CW'(m_q.size()), m_q.size() != 0, m_ovf};
  endfunction

  function automatic logic [NK+NC+CW+1:0] obs_vec();
    return {key_held, chan_active, ev_count, ev_valid, ev_overflow};
  endfunction

  function automatic void m_reset();
    m_held = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_strobe = '0;
  endfunction

  function automatic void m_cycle(bit brk, int idx, bit has_key, bit pop, bit clr);
    bit       acc = 0;
    bit       drop = 0;
    logic [7:0] ev = 8'h00;
    m_strobe = '0;
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (has_key) begin
      if (!brk && !m_held[idx]) begin
        m_held[idx] = 1'b1;
        m_strobe[(idx >= 12) ? 1 : 0] = 1'b1;
        ev = {1'b0, 7'(idx)};
        acc = 1;
      end else if (brk && m_held[idx]) begin
        m_held[idx] = 1'b0;
        ev = {1'b1, 7'(idx)};
        acc = 1;
      end
    end
    if (acc) begin
      if (m_q.size() < FD) m_q.push_back(ev);
      else drop = 1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic send(input logic [7:0] b, input logic pop, input logic clr);
    ps2_key_data = b;
    ps2_key_pressed = 1'b1;
    ev_pop = pop;
    ovf_clear = clr;
    @(posedge clock);
    #1;
    ps2_key_pressed = 1'b0;
    ev_pop = 1'b0;
    ovf_clear = 1'b0;
  endtask

  task automatic key_action(input bit brk, input int idx, input bit pop, input bit clr);
    if (kext[idx]) send(8'hE0, 1'b0, 1'b0);
    if (brk) send(8'hF0, 1'b0, 1'b0);
    send(kcode[idx], pop, clr);
    m_cycle(brk, idx, 1, pop, clr);
  endtask

  task automatic idle_cycle(input bit pop, input bit clr);
    ev_pop = pop;
    ovf_clear = clr;
    @(posedge clock);
    #1;
    ev_pop = 1'b0;
    ovf_clear = 1'b0;
    m_cycle(0, 0, 0, pop, clr);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    m_reset();
  endtask

  task automatic test_reset();
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", obs_vec());
    end
    checks++;
    if ({chan_strobe, ev_data} !== '0) begin
      errors++; $display("FAIL reset_strobe_data: got %h expected 0", {chan_strobe, ev_data});
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_make_break();
    key_action(0, KEY_W, 0, 0);
    checks++;
    if (chan_strobe !== 2'b10) begin
      errors++; $display("FAIL w_make_strobe: got %b expected 10", chan_strobe);
    end
    checks++;
    if (obs_vec() !== exp_vec() || ev_data !== 8'h0C) begin
      errors++; $display("FAIL w_make: got %h/%h expected %h/0c", obs_vec(), ev_data, exp_vec());
    end
    idle_cycle(0, 0);
    checks++;
    if (chan_strobe !== 2'b00) begin
      errors++; $display("FAIL w_strobe_width: got %b expected 00", chan_strobe);
    end
    key_action(1, KEY_W, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec() || key_held[KEY_W] !== 1'b0) begin
      errors++; $display("FAIL w_break: got %h expected %h", obs_vec(), exp_vec());
    end
    idle_cycle(1, 0);
    checks++;
    if (ev_data !== 8'h8C || ev_count !== 4'd1) begin
      errors++; $display("FAIL w_break_event: got %h/%0d expected 8c/1", ev_data, ev_count);
    end
    idle_cycle(1, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL w_drain: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_extended();
    key_action(0, KEY_UP, 0, 0);
    checks++;
    if (key_held[KEY_UP] !== 1'b1 || ev_data !== 8'h00 || chan_active !== 2'b01) begin
      errors++; $display("FAIL up_make: got held=%h data=%h ch=%b expected held[0]=1 00 01",
                         key_held, ev_data, chan_active);
    end
    key_action(1, KEY_UP, 0, 0);
    send(8'h75, 1'b0, 1'b0);
    m_cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec() || ev_count !== 4'd2) begin
      errors++; $display("FAIL up_break_keypad8: got %h expected %h", obs_vec(), exp_vec());
    end
    idle_cycle(1, 0);
    checks++;
    if (ev_data !== 8'h80) begin
      errors++; $display("FAIL up_break_event: got %h expected 80", ev_data);
    end
    idle_cycle(1, 0);
  endtask

  task automatic test_typematic();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      key_action(0, KEY_W, 0, 0);
      pulses += int'(chan_strobe[1]);
    end
    checks++;
    if (pulses != 1 || ev_count !== 4'd1 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL typematic: got pulses=%0d count=%0d expected 1/1", pulses, ev_count);
    end
    key_action(1, KEY_W, 0, 0);
    idle_cycle(1, 0);
    idle_cycle(1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) key_action(0, i, 0, 0);
    checks++;
    if (ev_count !== 4'd8 || ev_overflow !== 1'b1 || key_held !== 16'h01FF) begin
      errors++; $display("FAIL overflow_fill: got count=%0d ovf=%b held=%h expected 8/1/01ff",
                         ev_count, ev_overflow, key_held);
    end
    idle_cycle(0, 1);
    checks++;
    if (ev_overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clear: got %b expected 0", ev_overflow);
    end
    key_action(0, 9, 1, 0);
    checks++;
    if (ev_count !== 4'd8 || ev_data !== 8'h01 || ev_overflow !== 1'b0) begin
      errors++; $display("FAIL full_push_pop: got count=%0d data=%h ovf=%b expected 8/01/0",
                         ev_count, ev_data, ev_overflow);
    end
    key_action(0, 10, 0, 1);
    checks++;
    if (obs_vec() !== exp_vec() || ev_overflow !== 1'b1) begin
      errors++; $display("FAIL drop_beats_clear: got %h expected %h", obs_vec(), exp_vec());
    end
    do_reset();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(seq[i], 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== exp_vec() || chan_strobe !== 2'b00) begin
      errors++; $display("FAIL pause_silent: got %h expected %h", obs_vec(), exp_vec());
    end
    key_action(0, KEY_W, 0, 0);
    checks++;
    if (ev_count !== 4'd1 || ev_data !== 8'h0C) begin
      errors++; $display("FAIL after_pause: got count=%0d data=%h expected 1/0c", ev_count, ev_data);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    key_action(0, 13, 0, 0);
    send(8'hE0, 1'b0, 1'b0);
    #20;
    resetn = 1'b0;
    #1;
    checks++;
    if (key_held !== '0 || ev_valid !== 1'b0 || ev_count !== '0 || chan_active !== '0) begin
      errors++; $display("FAIL async_reset: got held=%h valid=%b count=%0d expected 0",
                         key_held, ev_valid, ev_count);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    m_reset();
    key_action(0, KEY_W, 0, 0);
    checks++;
    if (ev_count !== 4'd1 || ev_data !== 8'h0C || key_held[KEY_W] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_seq: got count=%0d data=%h expected 1/0c", ev_count, ev_data);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      int sel = $urandom_range(0, 11);
      if (sel <= 6) begin
        key_action(bit'($urandom_range(0, 1)), $urandom_range(0, NK - 1),
                   bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 7) == 0));
      end else if (sel <= 8) begin
        idle_cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
      end else if (sel == 9) begin
        case ($urandom_range(0, 3))
          0: begin send(8'hE0, 1'b0, 1'b0); send(8'hE0, 1'b0, 1'b0); end
          1: begin send(8'hF0, 1'b0, 1'b0); send(8'hF0, 1'b0, 1'b0); end
          2: begin send(8'hE0, 1'b0, 1'b0); send(8'hF0, 1'b0, 1'b0); send(8'hE1, 1'b0, 1'b0); end
          default: begin send(8'hF0, 1'b0, 1'b0); send(8'hE1, 1'b0, 1'b0); end
        endcase
        m_cycle(0, 0, 0, 0, 0);
      end else if (sel == 10) begin
        send(8'hE1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        m_cycle(0, 0, 0, 0, 0);
      end else begin
        if ($urandom_range(0, 1) == 0) send(8'h75, 1'b0, 1'b0);
        else begin send(8'hE0, 1'b0, 1'b0); send(8'h1D, 1'b0, 1'b0); end
        m_cycle(0, 0, 0, 0, 0);
      end
      checks++;
      if (obs_vec() !== exp_vec() || chan_strobe !== m_strobe) begin
        errors++; $display("FAIL random_state it=%0d: got %h/%b expected %h/%b",
                           it, obs_vec(), chan_strobe, exp_vec(), m_strobe);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (ev_data !== m_q[0]) begin
          errors++; $display("FAIL random_head it=%0d: got %h expected %h", it, ev_data, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_typematic();
    test_overflow();
    test_pause();
    test_reset_mid();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
